// File: rtl/usb_in_scheduler_if.sv
// Signals between the bulk-IN scheduler and its FIFO read port, USB RX decoder and TX encoder.
// The master modport is the scheduler's view; slave is the surrounding logic's view.
interface usb_in_scheduler_if;
    logic       fifo_empty;
    logic [6:0] fifo_count;
    logic [7:0] fifo_rdata;
    logic       fifo_read;
    logic       rx_token_in;
    logic       rx_ack;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ack;
    logic       tx_pkt_end;
    logic       tx_done;
    logic       busy;

    modport master (
        input  fifo_empty, fifo_count, fifo_rdata, rx_token_in, rx_ack, tx_byte_ack, tx_done,
        output fifo_read, tx_pkt_start, tx_pid, tx_byte, tx_byte_valid, tx_pkt_end, busy
    );

    modport slave (
        output fifo_empty, fifo_count, fifo_rdata, rx_token_in, rx_ack, tx_byte_ack, tx_done,
        input  fifo_read, tx_pkt_start, tx_pid, tx_byte, tx_byte_valid, tx_pkt_end, busy
    );
endinterface

// File: rtl/usb_in_scheduler.sv
// Bulk-IN sequencer: drains the FIFO into a replay buffer, answers IN tokens with DATA0/DATA1
// or NAK, and retransmits the buffered packet until the host ACKs it.
module usb_in_scheduler #(
    parameter int unsigned MAX_PKT     = 8,
    parameter int unsigned ACK_TIMEOUT = 400
) (
    input  logic               r_clk,
    input  logic               n_rst,
    usb_in_scheduler_if.master io_bus
);
    localparam int unsigned IdxW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [6:0] MaxLen   = 7'(MAX_PKT);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StSendPid,
        StSendData,
        StSendEnd,
        StWaitDone,
        StWaitAck,
        StNakPid,
        StNakWait
    } state_e;

    state_e          r_state, w_state_nxt;
    logic            r_toggle, w_toggle_nxt;
    logic            r_pending, w_pending_nxt;
    logic [6:0]      r_len, w_len_nxt;
    logic [IdxW-1:0] r_idx, w_idx_nxt;
    logic [TmrW-1:0] r_timer, w_timer_nxt;
    logic [7:0]      r_buf [MAX_PKT];

    logic            w_idx_last;
    logic            w_timeout;
    logic [6:0]      w_fill_len;

    assign w_idx_last = (7'(r_idx) == r_len - 7'd1);
    assign w_timeout  = (r_timer == TmrW'(ACK_TIMEOUT - 1));

    // A non-empty FIFO reporting zero bytes still yields a one-byte packet, never zero-length.
    always_comb begin
        w_fill_len = io_bus.fifo_count;
        if (io_bus.fifo_count > MaxLen) begin
            w_fill_len = MaxLen;
        end else if (io_bus.fifo_count == 7'd0) begin
            w_fill_len = 7'd1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_toggle_nxt  = r_toggle;
        w_pending_nxt = r_pending;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        unique case (r_state)
            StIdle: begin
                if (io_bus.rx_token_in) begin
                    if (r_pending) begin
                        w_state_nxt = StSendPid;
                    end else if (!io_bus.fifo_empty) begin
                        w_len_nxt   = w_fill_len;
                        w_idx_nxt   = '0;
                        w_state_nxt = StLoad;
                    end else begin
                        w_state_nxt = StNakPid;
                    end
                end
            end
            StLoad: begin
                w_idx_nxt = r_idx + IdxW'(1);
                if (w_idx_last) begin
                    w_pending_nxt = 1'b1;
                    w_idx_nxt     = '0;
                    w_state_nxt   = StSendPid;
                end
            end
            StSendPid: begin
                w_idx_nxt   = '0;
                w_state_nxt = StSendData;
            end
            StSendData: begin
                if (io_bus.tx_byte_ack) begin
                    w_idx_nxt = r_idx + IdxW'(1);
                    if (w_idx_last) begin
                        w_state_nxt = StSendEnd;
                    end
                end
            end
            StSendEnd: begin
                w_state_nxt = StWaitDone;
            end
            StWaitDone: begin
                if (io_bus.tx_done) begin
                    w_timer_nxt = '0;
                    w_state_nxt = StWaitAck;
                end
            end
            StWaitAck: begin
                w_timer_nxt = r_timer + TmrW'(1);
                // ACK has priority over a coincident token; the token is dropped.
                if (io_bus.rx_ack) begin
                    w_toggle_nxt  = ~r_toggle;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = StIdle;
                end else if (io_bus.rx_token_in) begin
                    w_state_nxt = StSendPid;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                end
            end
            StNakPid: begin
                w_state_nxt = StNakWait;
            end
            StNakWait: begin
                if (io_bus.tx_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= StIdle;
            r_toggle  <= 1'b0;
            r_pending <= 1'b0;
            r_len     <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_toggle  <= w_toggle_nxt;
            r_pending <= w_pending_nxt;
            r_len     <= w_len_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < MAX_PKT; i++) begin
                r_buf[i] <= '0;
            end
        end else if (r_state == StLoad) begin
            r_buf[r_idx] <= io_bus.fifo_rdata;
        end
    end

    // Moore outputs: decoded from state and registers only.
    always_comb begin
        io_bus.fifo_read     = 1'b0;
        io_bus.tx_pkt_start  = 1'b0;
        io_bus.tx_pid        = 4'b0000;
        io_bus.tx_byte       = 8'h00;
        io_bus.tx_byte_valid = 1'b0;
        io_bus.tx_pkt_end    = 1'b0;
        io_bus.busy          = (r_state != StIdle);
        unique case (r_state)
            StLoad: begin
                io_bus.fifo_read = 1'b1;
            end
            StSendPid: begin
                io_bus.tx_pkt_start = 1'b1;
                io_bus.tx_pid       = r_toggle ? PidData1 : PidData0;
            end
            StSendData: begin
                io_bus.tx_pid        = r_toggle ? PidData1 : PidData0;
                io_bus.tx_byte       = r_buf[r_idx];
                io_bus.tx_byte_valid = 1'b1;
            end
            StSendEnd: begin
                io_bus.tx_pid     = r_toggle ? PidData1 : PidData0;
                io_bus.tx_pkt_end = 1'b1;
            end
            StWaitDone: begin
                io_bus.tx_pid = r_toggle ? PidData1 : PidData0;
            end
            StNakPid: begin
                io_bus.tx_pkt_start = 1'b1;
                io_bus.tx_pkt_end   = 1'b1;
                io_bus.tx_pid       = PidNak;
            end
            StNakWait: begin
                io_bus.tx_pid = PidNak;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_usb_in_scheduler.sv
// Directed bench for usb_in_scheduler: a table of token transactions plus hand-written
// sequences for ACK timeout, token replay, ACK/token collision and asynchronous reset.
module tb_usb_in_scheduler;
    localparam logic [3:0] Data0 = 4'b0011;
    localparam logic [3:0] Data1 = 4'b1011;
    localparam logic [3:0] Nak   = 4'b1010;

    logic r_clk = 1'b0;
    logic n_rst;

    usb_in_scheduler_if bus ();

    usb_in_scheduler #(
        .MAX_PKT    (8),
        .ACK_TIMEOUT(400)
    ) dut (
        .r_clk (r_clk),
        .n_rst (n_rst),
        .io_bus(bus)
    );

    always #5 r_clk = ~r_clk;

    // Show-ahead FIFO model.
    logic [7:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_count = 7'(wr_ptr - rd_ptr);
    assign bus.fifo_rdata = mem[8'(rd_ptr)];
    always @(posedge r_clk) if (bus.fifo_read) rd_ptr <= rd_ptr + 1;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] got [64];
    int         x_lat, x_pops, x_nb, x_end, x_tmo, x_stab;
    logic [3:0] x_pid;

    typedef struct {
        int         fill;
        int         stall;
        bit         do_ack;
        logic [3:0] pid;
        int         len;
        int         lat;
        int         pops;
        int         cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] val(input int k);
        return 8'(161 + 17 * k);
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[8'(wr_ptr)] = val(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic token();
        bus.rx_token_in = 1'b1;
        tick();
        bus.rx_token_in = 1'b0;
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
    endtask

    task automatic done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    // Called in the cycle after the token edge; plays the encoder until tx_done is returned.
    task automatic do_xfer(input int stall);
        int         c;
        int         guard;
        logic [7:0] b0;
        x_lat = 0; x_pops = 0; x_nb = 0; x_end = 0; x_tmo = 0; x_stab = 0; x_pid = '0;
        c = 1;
        while (!bus.tx_pkt_start) begin
            if (bus.fifo_read) x_pops++;
            if (c >= 200) begin
                x_tmo = 1;
                return;
            end
            c++;
            tick();
        end
        x_lat = c;
        x_pid = bus.tx_pid;
        if (x_pid == Nak) x_end = int'(bus.tx_pkt_end);
        tick();
        if (x_pid != Nak) begin
            guard = 0;
            while (!bus.tx_pkt_end) begin
                if (!bus.tx_byte_valid || x_nb >= 64 || guard > 2000) begin
                    x_tmo = 1;
                    break;
                end
                b0 = bus.tx_byte;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    guard++;
                    if (!bus.tx_byte_valid || bus.tx_byte != b0) x_stab++;
                end
                got[x_nb] = b0;
                x_nb++;
                bus.tx_byte_ack = 1'b1;
                tick();
                bus.tx_byte_ack = 1'b0;
                guard++;
            end
            x_end = int'(bus.tx_pkt_end);
            tick();
        end
        done();
    endtask

    task automatic check_pkt(input string nm, input logic [3:0] pid, input int len,
                             input int lat, input int pops, input int base);
        int bad;
        chk({nm, " no timeout"}, x_tmo, 0);
        chk({nm, " start latency"}, x_lat, lat);
        chk({nm, " fifo pops"}, x_pops, pops);
        chk({nm, " pid"}, int'(x_pid), int'(pid));
        chk({nm, " byte count"}, x_nb, len);
        chk({nm, " pkt_end seen"}, x_end, 1);
        chk({nm, " byte stability"}, x_stab, 0);
        bad = 0;
        for (int i = 0; i < x_nb && i < len; i++) begin
            if (got[i] != val(base + i)) bad++;
        end
        chk({nm, " wrong bytes"}, bad, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ptr;
        int base;
        int c;

        tbl[0] = '{fill:3,  stall:0, do_ack:1'b1, pid:Data0, len:3, lat:4, pops:3, cnt:0};
        tbl[1] = '{fill:0,  stall:0, do_ack:1'b1, pid:Nak,   len:0, lat:1, pops:0, cnt:0};
        tbl[2] = '{fill:20, stall:0, do_ack:1'b1, pid:Data1, len:8, lat:9, pops:8, cnt:12};
        tbl[3] = '{fill:0,  stall:0, do_ack:1'b1, pid:Data0, len:8, lat:9, pops:8, cnt:4};
        tbl[4] = '{fill:0,  stall:5, do_ack:1'b1, pid:Data1, len:4, lat:5, pops:4, cnt:0};
        tbl[5] = '{fill:1,  stall:1, do_ack:1'b1, pid:Data0, len:1, lat:2, pops:1, cnt:0};

        exp_ptr = 0;
        n_rst = 1'b0;
        bus.rx_token_in = 1'b0;
        bus.rx_ack      = 1'b0;
        bus.tx_byte_ack = 1'b0;
        bus.tx_done     = 1'b0;

        #3;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset fifo_read", int'(bus.fifo_read), 0);
        chk("reset tx_pkt_start", int'(bus.tx_pkt_start), 0);
        chk("reset tx_byte_valid", int'(bus.tx_byte_valid), 0);
        chk("reset tx_pkt_end", int'(bus.tx_pkt_end), 0);
        chk("reset tx_pid", int'(bus.tx_pid), 0);
        chk("reset tx_byte", int'(bus.tx_byte), 0);
        #20;
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].fill);
            base = exp_ptr;
            token();
            do_xfer(tbl[i].stall);
            check_pkt($sformatf("vec%0d", i), tbl[i].pid, tbl[i].len, tbl[i].lat,
                      tbl[i].pops, base);
            exp_ptr += tbl[i].len;
            if (tbl[i].do_ack) ack();
            chk($sformatf("vec%0d busy after", i), int'(bus.busy), 0);
            chk($sformatf("vec%0d fifo_count after", i), int'(bus.fifo_count), tbl[i].cnt);
        end

        // Lost ACK: timeout, then replay on the next token without touching the FIFO.
        push(3);
        base = exp_ptr;
        token();
        do_xfer(0);
        check_pkt("timeout pkt", Data1, 3, 4, 3, base);
        exp_ptr += 3;
        c = 0;
        while (bus.busy && c < 1000) begin
            c++;
            tick();
        end
        chk("ack timeout cycles", c, 400);
        push(2);
        token();
        do_xfer(0);
        check_pkt("replay after timeout", Data1, 3, 1, 0, base);
        chk("replay fifo_count", int'(bus.fifo_count), 2);

        // Token while waiting for ACK: immediate replay.
        token();
        do_xfer(0);
        check_pkt("replay on token", Data1, 3, 1, 0, base);

        // ACK and token together: ACK wins, token dropped.
        bus.rx_ack = 1'b1;
        bus.rx_token_in = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        bus.rx_token_in = 1'b0;
        chk("collision busy", int'(bus.busy), 0);
        tick();
        chk("collision token dropped", int'(bus.busy), 0);
        chk("collision fifo_count", int'(bus.fifo_count), 2);

        base = exp_ptr;
        token();
        do_xfer(0);
        check_pkt("fresh after collision", Data0, 2, 3, 2, base);
        exp_ptr += 2;
        ack();

        // Asynchronous reset in the middle of SEND_DATA.
        push(4);
        token();
        c = 0;
        while (!bus.tx_byte_valid && c < 50) begin
            tick();
            c++;
        end
        chk("pre-reset in send_data", int'(bus.tx_byte_valid), 1);
        chk("pre-reset pid", int'(bus.tx_pid), int'(Data1));
        bus.tx_byte_ack = 1'b1;
        tick();
        bus.tx_byte_ack = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("async reset busy", int'(bus.busy), 0);
        chk("async reset tx_byte_valid", int'(bus.tx_byte_valid), 0);
        chk("async reset tx_pid", int'(bus.tx_pid), 0);
        chk("async reset tx_byte", int'(bus.tx_byte), 0);
        chk("async reset tx_pkt_end", int'(bus.tx_pkt_end), 0);
        chk("async reset tx_pkt_start", int'(bus.tx_pkt_start), 0);
        chk("async reset fifo_read", int'(bus.fifo_read), 0);
        #2;
        n_rst = 1'b1;
        exp_ptr += 4;
        tick();
        push(2);
        base = exp_ptr;
        token();
        do_xfer(0);
        check_pkt("after reset", Data0, 2, 3, 2, base);
        exp_ptr += 2;
        ack();
        chk("final busy", int'(bus.busy), 0);
        chk("final fifo_count", int'(bus.fifo_count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_in_scheduler.md
# usb_in_scheduler

Sequences bulk-IN transfers on the USB side of the Ethernet-to-USB bridge, in the r_clk domain. It answers each host IN token with a DATA0/DATA1 packet drained from the Ethernet-to-USB FIFO, or with NAK when the FIFO is empty. It holds every sent packet in a local replay buffer until the host ACKs it, and retransmits it on a lost or corrupted ACK. It sits between the FIFO read port, the USB RX token/handshake decoder, and the USB TX encoder.

## Interface
- MAX_PKT, 8: maximum data bytes per packet and replay-buffer depth (2..64).
- ACK_TIMEOUT, 400: r_clk cycles to wait for ACK after the encoder finishes a data packet.
- r_clk  in  1  USB-domain clock; all logic is on its rising edge; the only clock.
- n_rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO has no bytes.
- fifo_count  in  7  bytes currently in the FIFO.
- fifo_rdata  in  8  show-ahead FIFO head byte, valid in the same cycle as fifo_read.
- fifo_read  out  1  pop FIFO head this cycle.
- rx_token_in  in  1  one-cycle pulse: IN token addressed to this endpoint.
- rx_ack  in  1  one-cycle pulse: host ACK handshake received.
- tx_pkt_start  out  1  one-cycle pulse: encoder begins packet with tx_pid.
- tx_pid  out  4  PID for current packet; held from tx_pkt_start to tx_done.
- tx_byte  out  8  current data byte.
- tx_byte_valid  out  1  tx_byte is valid.
- tx_byte_ack  in  1  encoder consumed tx_byte.
- tx_pkt_end  out  1  one-cycle pulse: no more bytes; encoder appends CRC16/EOP.
- tx_done  in  1  one-cycle pulse: encoder finished EOP.
- busy  out  1  state is not IDLE.

## Operation
- PIDs: DATA0=4'b0011, DATA1=4'b1011, NAK=4'b1010.
- Registers:
  - state
  - toggle: 0 selects DATA0; reset 0.
  - pending: an unacked packet is in the buffer; reset 0.
  - len: packet length, 1..MAX_PKT.
  - idx: byte index into the buffer.
  - timer: ACK timeout counter.
- IDLE, on rx_token_in:
  - pending=1 goes to SEND_PID. This is a replay; the FIFO is untouched.
  - Otherwise, fifo_empty=0 latches len=min(fifo_count, MAX_PKT) and idx=0, then goes to LOAD.
  - Otherwise goes to NAK_PID.
- LOAD: fifo_read=1 every cycle. buf[idx]<=fifo_rdata and idx++. After len pops, set pending=1 and idx=0, then go to SEND_PID.
- SEND_PID: tx_pkt_start=1 for one cycle with tx_pid=toggle?DATA1:DATA0. Set idx=0 and go to SEND_DATA.
- SEND_DATA: tx_byte_valid=1 and tx_byte=buf[idx].
  - On tx_byte_ack, idx++.
  - On ack of byte len-1, go to SEND_END.
  - tx_byte_valid stays high until acked.
- SEND_END: tx_pkt_end=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE: on tx_done, clear timer and go to WAIT_ACK.
- WAIT_ACK: timer increments every cycle.
  - rx_ack: flip toggle, set pending=0, go to IDLE.
  - Else rx_token_in: the host missed the packet; go to SEND_PID to replay with the same PID and bytes.
  - Else timer==ACK_TIMEOUT-1: go to IDLE with pending=1.
- NAK_PID: tx_pkt_start=1 with tx_pid=NAK and no data bytes. tx_pkt_end=1 in the same cycle. Go to NAK_WAIT.
- NAK_WAIT: on tx_done, go to IDLE.
- Ignored inputs:
  - rx_token_in outside IDLE/WAIT_ACK.
  - rx_ack outside WAIT_ACK.
  - tx_byte_ack outside SEND_DATA.
- Zero-length data packets are never generated.

## Timing
- Reset values:
  - Outputs: fifo_read, tx_pkt_start, tx_byte_valid, tx_pkt_end, busy are 0; tx_pid=4'b0000; tx_byte=8'h00.
  - State and registers: state=IDLE, toggle=0, pending=0, timer=0, idx=0, len=0.
- Outputs are Moore-decoded from state and registers; none are combinational from inputs.
- Token sampled at edge T, start pulse high in cycle:
  - Fresh data: T+len+1, with fifo_read high in cycles T+1..T+len.
  - Replay: T+1.
  - NAK: T+1.
- First tx_byte_valid is the cycle after tx_pkt_start.
- Back-to-back acks send one byte per cycle.
- tx_pkt_end comes one cycle after the last ack.
- Timeout fires exactly ACK_TIMEOUT cycles after the tx_done edge.
- Simultaneous rx_ack and rx_token_in in WAIT_ACK: ACK wins, the block returns to IDLE, and the token is dropped.
- FIFO grows during LOAD: len is not re-evaluated.
- Reset mid-operation: all of the above cleared; buffered bytes are discarded and toggle returns to DATA0.

## Test plan
- Fresh packet with FIFO holding 3 bytes (A1,B2,C3):
  - Token → 3 fifo_read pulses, then start with PID 0011, bytes A1,B2,C3, end.
  - Then tx_done, rx_ack → toggle=1 and fifo_count=0.
- Empty FIFO:
  - Token → start at T+1 with PID 1010, tx_pkt_end in the same cycle, no fifo_read.
  - After tx_done, busy=0.
- Length limit with fifo_count=20 and MAX_PKT=8:
  - Token → exactly 8 pops and an 8-byte DATA0 packet; fifo_count ends at 12.
  - After ACK, the next token sends the next 8 bytes as DATA1.
- Lost ACK, two variants:
  - No rx_ack for 400 cycles → IDLE with pending=1. The next token replays the identical bytes and PID with zero fifo_read.
  - rx_token_in in WAIT_ACK → immediate replay.
- Encoder backpressure: hold tx_byte_ack low for 5 cycles per byte → tx_byte stable and tx_byte_valid held, with no byte skipped.
- Reset mid-SEND_DATA: assert n_rst low asynchronously → all outputs 0 immediately. After release, the next packet uses PID DATA0.
